// File: rtl/dco_ctrl.sv
// DCO code controller: binary search toward the detector's balance point, then
// unit-step tracking with a lock qualifier. The code saturates to 0..128.
module dco_ctrl #(
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned CODE_INIT  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       up,
   input  logic       dn,
   output logic [7:0] dco_code,
   output logic       lock,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSettle = 3'd1,
      StSearch = 3'd2,
      StTrack  = 3'd3,
      StLocked = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DirNone = 2'd0,
      DirUp   = 2'd1,
      DirDn   = 2'd2,
      DirHold = 2'd3
   } dir_t;

   localparam logic [7:0] CodeInit   = 8'(CODE_INIT);
   localparam logic [7:0] StepInit   = 8'(CODE_INIT / 2);
   localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] LockCnt    = 8'(LOCK_CNT);

   state_t     state_q, state_d;
   logic [7:0] code_q, code_d;
   logic [7:0] step_q, step_d;
   logic       lock_q, lock_d;
   logic [7:0] settle_q, settle_d;
   logic [7:0] lcnt_q, lcnt_d;
   logic       search_q, search_d;
   dir_t       prev_q, prev_d;  // previous decision, hold included
   dir_t       last_q, last_d;  // previous non-hold decision

   dir_t       dir;
   logic [8:0] delta9;
   logic [8:0] sum9;
   logic [7:0] add_sat;
   logic [7:0] sub_sat;
   logic [7:0] lcnt_inc;
   logic       qual_inc;
   logic       qual_clr;

   assign dir = (up && !dn) ? DirUp : ((dn && !up) ? DirDn : DirHold);

   // 9-bit intermediate so the sum can exceed 128 and be clamped instead of wrapping
   assign delta9  = search_q ? {1'b0, step_q} : 9'd1;
   assign sum9    = {1'b0, code_q} + delta9;
   assign add_sat = (sum9 > 9'd128) ? 8'd128 : sum9[7:0];
   assign sub_sat = (delta9 > {1'b0, code_q}) ? 8'd0 : 8'({1'b0, code_q} - delta9);

   assign lcnt_inc = (lcnt_q == 8'd255) ? 8'd255 : lcnt_q + 8'd1;
   assign qual_inc = (dir == DirHold) || (dir == DirUp && last_q == DirDn) ||
                     (dir == DirDn && last_q == DirUp);
   assign qual_clr = (dir != DirHold) && (dir == prev_q);

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      step_d   = step_q;
      lock_d   = lock_q;
      settle_d = settle_q;
      lcnt_d   = lcnt_q;
      search_d = search_q;
      prev_d   = prev_q;
      last_d   = last_q;

      case (state_q)
         StIdle: begin
            if (en) begin
               state_d  = StSettle;
               search_d = 1'b1;
               settle_d = 8'd0;
            end
         end
         StSettle: begin
            if (settle_q == SettleLast) begin
               settle_d = 8'd0;
               if (search_q)    state_d = StSearch;
               else if (lock_q) state_d = StLocked;
               else             state_d = StTrack;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         StSearch: begin
            state_d = StSettle;
            case (dir)
               DirUp, DirDn: begin
                  code_d = (dir == DirUp) ? add_sat : sub_sat;
                  step_d = step_q >> 1;
                  if (step_q <= 8'd1) search_d = 1'b0;
               end
               default: search_d = 1'b0;
            endcase
         end
         StTrack, StLocked: begin
            state_d = StSettle;
            case (dir)
               DirUp:   code_d = add_sat;
               DirDn:   code_d = sub_sat;
               default: code_d = code_q;
            endcase
            if (qual_clr) begin
               lcnt_d = 8'd0;
               lock_d = 1'b0;
            end else if (qual_inc) begin
               lcnt_d = lcnt_inc;
               if (lcnt_inc >= LockCnt) lock_d = 1'b1;
            end
            prev_d = dir;
            if (dir != DirHold) last_d = dir;
         end
         default: state_d = StIdle;
      endcase

      if (!en) begin
         state_d  = StIdle;
         code_d   = CodeInit;
         step_d   = StepInit;
         lock_d   = 1'b0;
         settle_d = 8'd0;
         lcnt_d   = 8'd0;
         search_d = 1'b0;
         prev_d   = DirNone;
         last_d   = DirNone;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         code_q   <= CodeInit;
         step_q   <= StepInit;
         lock_q   <= 1'b0;
         settle_q <= 8'd0;
         lcnt_q   <= 8'd0;
         search_q <= 1'b0;
         prev_q   <= DirNone;
         last_q   <= DirNone;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         step_q   <= step_d;
         lock_q   <= lock_d;
         settle_q <= settle_d;
         lcnt_q   <= lcnt_d;
         search_q <= search_d;
         prev_q   <= prev_d;
         last_q   <= last_d;
      end
   end

   assign dco_code = code_q;
   assign lock     = lock_q;
   assign state    = state_q;

endmodule

// File: tb/tb_dco_ctrl.sv
// Bench for dco_ctrl: directed scenarios plus randomized detector inputs, every cycle
// compared against a decision-level model of the controller.
module tb_dco_ctrl;

   localparam int SETTLE_CYC = 4;
   localparam int LOCK_CNT   = 8;
   localparam int CODE_INIT  = 64;

   logic       clk = 1'b0;
   logic       reset, en, up, dn;
   logic [7:0] dco_code;
   logic       lock;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   // Model: cycles left before the next decision, plus the controller's visible results
   bit m_active, m_search, m_lock;
   int m_wait, m_code, m_step, m_cnt, m_prev, m_last;

   always #5 clk = ~clk;

   dco_ctrl #(
      .SETTLE_CYC(SETTLE_CYC),
      .LOCK_CNT  (LOCK_CNT),
      .CODE_INIT (CODE_INIT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .up      (up),
      .dn      (dn),
      .dco_code(dco_code),
      .lock    (lock),
      .state   (state)
   );

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_idle();
      m_active = 0; m_search = 0; m_lock = 0;
      m_wait = 0; m_code = CODE_INIT; m_step = CODE_INIT / 2;
      m_cnt = 0; m_prev = 2; m_last = 0;
   endfunction

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : ((v > 128) ? 128 : v);
   endfunction

   function automatic int exp_state();
      if (!m_active)   return 0;
      if (m_wait > 0)  return 1;
      if (m_search)    return 2;
      return m_lock ? 4 : 3;
   endfunction

   function automatic bit at_decision();
      return en && m_active && (m_wait == 0);
   endfunction

   task automatic model_edge();
      int d;
      if (!en) begin
         model_idle();
         return;
      end
      if (!m_active) begin
         m_active = 1; m_search = 1; m_wait = SETTLE_CYC;
         return;
      end
      if (m_wait > 0) begin
         m_wait--;
         return;
      end
      d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
      if (m_search) begin
         if (d == 0) m_search = 0;
         else begin
            m_code = clamp(m_code + d * m_step);
            if (m_step <= 1) m_search = 0;
            m_step = m_step / 2;
         end
      end else begin
         m_code = clamp(m_code + d);
         if (d != 0 && d == m_prev) begin
            m_cnt = 0; m_lock = 0;
         end else if (d == 0 || d == -m_last) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (m_cnt >= LOCK_CNT) m_lock = 1;
         end
         m_prev = d;
         if (d != 0) m_last = d;
      end
      m_wait = SETTLE_CYC;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("state", {6'b0, state}, 9'(exp_state()));
      check("code", {1'b0, dco_code}, 9'(m_code));
      check("lock", {8'b0, lock}, 9'(m_lock));
   endtask

   // mode 0: steer toward tgt, 1: up only, 2: up and dn both high, 3: random
   task automatic decide(input int mode, input int tgt);
      bit is_dec;
      for (int k = 0; k < 300; k++) begin
         is_dec = at_decision();
         if (is_dec) begin
            case (mode)
               0:       begin up = (m_code < tgt); dn = (m_code > tgt); end
               1:       begin up = 1'b1; dn = 1'b0; end
               2:       begin up = 1'b1; dn = 1'b1; end
               default: begin up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1)); end
            endcase
         end else begin
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
         end
         tick();
         if (is_dec) break;
      end
   endtask

   task automatic to_decision();
      for (int k = 0; k < SETTLE_CYC + 4; k++) begin
         if (at_decision()) break;
         up = 1'($urandom_range(0, 1));
         dn = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   initial begin
      int exp_seq[5];
      int tgt;
      exp_seq = '{96, 112, 104, 100, 100};

      reset = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0;
      model_idle();
      #12;
      check("rst_code", {1'b0, dco_code}, 9'd64);
      check("rst_lock", {8'b0, lock}, 9'd0);
      check("rst_state", {6'b0, state}, 9'd0);
      @(negedge clk);
      reset = 1'b0;
      en = 1'b1;

      // Binary search toward 100
      for (int i = 0; i < 5; i++) begin
         decide(0, 100);
         check("search_seq", {1'b0, dco_code}, 9'(exp_seq[i]));
      end
      to_decision();
      check("search_to_track", {6'b0, state}, 9'd3);

      // Holding at 100 qualifies every decision
      repeat (7) decide(0, 100);
      check("lock_pre", {8'b0, lock}, 9'd0);
      decide(0, 100);
      check("lock_8th", {8'b0, lock}, 9'd1);
      to_decision();
      check("locked_state", {6'b0, state}, 9'd4);

      decide(1, 0);
      check("loss_first", {8'b0, lock}, 9'd1);
      decide(1, 0);
      check("loss_lock", {8'b0, lock}, 9'd0);
      check("loss_code", {1'b0, dco_code}, 9'd102);
      to_decision();
      check("loss_state", {6'b0, state}, 9'd3);

      // Asynchronous reset while tracking at 100
      repeat (2) decide(0, 100);
      to_decision();
      check("pre_rst_code", {1'b0, dco_code}, 9'd100);
      #2 reset = 1'b1;
      #1;
      check("arst_code", {1'b0, dco_code}, 9'd64);
      check("arst_lock", {8'b0, lock}, 9'd0);
      check("arst_state", {6'b0, state}, 9'd0);
      model_idle();
      @(negedge clk);
      reset = 1'b0;

      // Saturation with up held
      repeat (6) decide(1, 0);
      check("sat_search", {1'b0, dco_code}, 9'd127);
      repeat (3) decide(1, 0);
      check("sat_track", {1'b0, dco_code}, 9'd128);
      check("sat_nolock", {8'b0, lock}, 9'd0);

      // up and dn both high during search
      en = 1'b0;
      tick();
      en = 1'b1;
      decide(2, 0);
      check("both_code", {1'b0, dco_code}, 9'd64);
      to_decision();
      check("both_track", {6'b0, state}, 9'd3);

      // en dropped in the middle of SETTLE
      decide(1, 0);
      tick();
      tick();
      en = 1'b0;
      tick();
      check("endrop_state", {6'b0, state}, 9'd0);
      check("endrop_code", {1'b0, dco_code}, 9'd64);
      en = 1'b1;

      // Randomized targets and detector noise, occasional run-request drops
      repeat (30) begin
         tgt = int'($urandom_range(0, 128));
         if ($urandom_range(0, 3) == 0) begin
            en = 1'b0;
            tick();
            en = 1'b1;
         end
         repeat (15) decide(($urandom_range(0, 2) == 0) ? 3 : 0, tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
